// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream and instruction-memory write bus for prog_loader
//
// Ports/signals:
//   in_valid, in_data[7:0], in_ready : byte stream into the loader (valid/ready)
//   imem_we, imem_addr[31:0], imem_wdata[31:0] : registered instruction-memory write port
// Modports:
//   slave  : the loader (consumes the stream, drives the memory write)
//   master : the environment (drives the stream, observes the memory write)

interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time framed program loader holding the cpu in reset until loaded
//
// Frame: 2-byte LE word count N, N little-endian 32-bit words, then (optionally) one
// checksum byte equal to the XOR of all payload bytes.
// Optional feature macro: LOADER_CHECKSUM_EN (defined = checksum byte expected and verified).
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : prog_loader_if.slave (in_valid/in_data/in_ready stream, imem_we/imem_addr/imem_wdata)
//   reload  : single-cycle pulse, restarts loading from DONE or ERR
//   cpu_rst : active-high reset to the cpu, released only after a successful load
//   done    : image loaded (and verified)
//   err     : load failed (oversize count or checksum mismatch)

module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    prog_loader_if.slave    bus,
    input  logic            reload,
    output logic            cpu_rst,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state, state_next;
    logic [15:0] count, count_next;
    logic [15:0] word_idx, word_idx_next;
    logic [1:0]  byte_cnt, byte_cnt_next;
    logic [23:0] shift, shift_next;
    logic        we_next;
    logic [31:0] addr_next;
    logic [31:0] wdata_next;
    logic        accept;
    logic [15:0] hdr_count;
    logic [15:0] idx_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum, csum_next;
`endif

    // in_ready is a registered copy of "state accepts bytes", so it is always
    // consistent with the current state and never depends on in_valid.
    assign accept    = bus.in_valid & bus.in_ready;
    assign hdr_count = {bus.in_data, count[7:0]};
    assign idx_inc   = word_idx + 16'd1;

    always_comb begin
        state_next    = state;
        count_next    = count;
        word_idx_next = word_idx;
        byte_cnt_next = byte_cnt;
        shift_next    = shift;
        we_next       = 1'b0;
        addr_next     = bus.imem_addr;
        wdata_next    = bus.imem_wdata;
`ifdef LOADER_CHECKSUM_EN
        csum_next     = csum;
`endif

        unique case (state)
            HDR0: begin
                if (accept) begin
                    count_next = {8'h00, bus.in_data};
                    state_next = HDR1;
                end
            end

            HDR1: begin
                if (accept) begin
                    count_next = hdr_count;
                    if ({16'h0000, hdr_count} > MAX_WORDS) begin
                        state_next = ERR;
                    end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    // Bytes shift in from the top so that after three bytes the
                    // first one sits in [7:0]; the fourth byte completes [31:24].
                    shift_next    = {bus.in_data, shift[23:8]};
                    byte_cnt_next = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_next     = csum ^ bus.in_data;
`endif
                    if (byte_cnt == 2'd3) begin
                        we_next       = 1'b1;
                        addr_next     = BASE_ADDR + {14'd0, word_idx, 2'b00};
                        wdata_next    = {bus.in_data, shift};
                        word_idx_next = idx_inc;
                        if (idx_inc == count) begin
`ifdef LOADER_CHECKSUM_EN
                            state_next = CSUM;
`else
                            state_next = DONE;
`endif
                        end
                    end
                end
            end

            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_next = (bus.in_data == csum) ? DONE : ERR;
                end
`else
                state_next = HDR0;
`endif
            end

            DONE, ERR: begin
                if (reload) begin
                    state_next    = HDR0;
                    count_next    = 16'd0;
                    word_idx_next = 16'd0;
                    byte_cnt_next = 2'd0;
                    shift_next    = 24'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_next     = 8'd0;
`endif
                end
            end

            default: begin
                state_next = HDR0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= HDR0;
            count          <= 16'd0;
            word_idx       <= 16'd0;
            byte_cnt       <= 2'd0;
            shift          <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
            bus.in_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'd0;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            word_idx       <= word_idx_next;
            byte_cnt       <= byte_cnt_next;
            shift          <= shift_next;
`ifdef LOADER_CHECKSUM_EN
            csum           <= csum_next;
`endif
            bus.in_ready   <= (state_next != DONE) && (state_next != ERR);
            bus.imem_we    <= we_next;
            bus.imem_addr  <= addr_next;
            bus.imem_wdata <= wdata_next;
            cpu_rst        <= (state_next != DONE);
            done           <= (state_next == DONE);
            err            <= (state_next == ERR);
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of `cpu`. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into instruction memory starting at `BASE_ADDR`. It holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.

## Interface
- `BASE_ADDR`, default 32'h1000: byte address of the first written word.
- `MAX_WORDS`, default 1024: largest accepted word count. A larger header count → ERR.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `reload`  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  32  write byte address, word-aligned.
- `imem_wdata`  out  32  write data.
- `cpu_rst`  out  1  active-high reset to `cpu`.
- `done`  out  1  image loaded and verified.
- `err`  out  1  load failed.

## Operation
- Frame format:
  - 2-byte word count N, little-endian.
  - N×4 payload bytes; each word is little-endian (first byte goes to [7:0]).
  - 1 checksum byte, equal to the XOR of all payload bytes only.
- A byte is accepted on a rising edge where `in_valid & in_ready`.
- States:
  - HDR0: accept count[7:0] → HDR1.
  - HDR1: accept count[15:8]. If the count exceeds `MAX_WORDS` → ERR. If the count is 0 → CSUM. Otherwise → DATA.
  - DATA: accept bytes into a 2-bit byte counter and shift register. On the 4th byte, issue a write and increment the word index. After word N → CSUM.
  - CSUM: accept one byte. If it matches the running XOR → DONE, otherwise → ERR.
  - DONE: `done`=1, `cpu_rst`=0. Ignores input.
  - ERR: `err`=1, `cpu_rst`=1. Ignores input.
- `reload` in DONE/ERR → HDR0, clearing the XOR, counters, `done` and `err`, and setting `cpu_rst`=1. `reload` in any other state is ignored.
- `imem_addr` = `BASE_ADDR` + 4×word_index. The index is 16-bit; the address is computed in 32 bits with no wrap check.
- `in_ready`=1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERR.
- Back-to-back bytes, one per cycle, are accepted with no bubbles.

## Timing
- Reset values:
  - State = HDR0.
  - `in_ready`=1, `cpu_rst`=1.
  - `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0.
  - `done`=0, `err`=0.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is high for exactly the one cycle after the edge that accepted a word's 4th byte. Address and data hold until the next write.
- `cpu_rst` falls, and `done` rises, on the cycle after the edge that accepted a correct checksum byte.
- `err` rises on the cycle after the edge that accepted the failing byte: header byte 1 or the checksum.
- Reset asserted mid-load: outputs return to their reset values immediately. Any partial word is discarded and no `imem_we` is produced.
- An `in_valid` deassertion in the middle of a word stalls the loader. Partial word state is kept indefinitely.
- All outputs are registered. There is no combinational path from `in_valid` to any output.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CSUM state exists as described.
- `LOADER_CHECKSUM_EN` undefined:
  - No checksum byte is expected.
  - After word N, go directly to DONE.
  - Count 0 goes directly to DONE.
  - ERR is reachable only through an oversize count.
  - The XOR logic is removed.

## Test plan
- Nominal load (checksum enabled): stream 04 00, then 03 A3 C4 FF, 23 A4 64 00, 33 E2 62 00, E3 0A 42 FE, then 9E. Required:
  - 4 `imem_we` pulses: FFC4A303@1000, 0064A423@1004, 0062E233@1008, FE420AE3@100C.
  - Then `cpu_rst`=0 and `done`=1.
- Bad checksum: same stream ending in 9F. Required:
  - All 4 writes still occur.
  - `err`=1, `cpu_rst` stays 1, `in_ready`=0.
  - `reload` then the correct stream → `done`=1.
- Oversize count: header 01 04 (1025). Required:
  - `err`=1 on the cycle after the second byte.
  - Zero writes.
- Stalled stream: valid deasserted for 5 cycles after the 2nd byte of the word destined for 1004. Required:
  - Write 0064A423@1004 occurs exactly once.
  - Strobe is 1 cycle wide.
- Reset mid-load: `rst` low after 2 bytes of word 2, then restart the full stream. Required:
  - `cpu_rst`=1 throughout reset.
  - Address restarts at 1000.
  - Final `done`=1.
- Zero count: header 00 00, checksum 00. Required:
  - No writes.
  - `done`=1.
  - Without `LOADER_CHECKSUM_EN`: `done`=1 immediately after the header.
